// File: rtl/regs_writer_pkg.sv
// regs_writer_pkg: shared widths, x0 constant and writeback source encoding
package regs_writer_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;
  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_LSU} wb_src_e;
endpackage

// File: rtl/regs_writer_fifo.sv
// regs_writer_fifo: synchronous FIFO with wrap-bit pointers for LSU results
module regs_writer_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic push_ok, pop_ok;
  assign o_empty = wr_q == rd_q;
  assign o_full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign o_dat = mem_q[rd_q[AW-1:0]];
  assign push_ok = i_push && !o_full;
  assign pop_ok = i_pop && !o_empty;
  assign wr_d = wr_q + {{AW{1'b0}}, push_ok};
  assign rd_d = rd_q + {{AW{1'b0}}, pop_ok};
  // pointer registers; extra MSB distinguishes full from empty
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // storage needs no reset, the pointers define which entries are live
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= i_dat;
  end
endmodule

// File: rtl/regs_writer.sv
// regs_writer: merges ALU and LSU writebacks into one registered regfile write port
module regs_writer
  import regs_writer_pkg::*;
#(
  parameter int LSU_DEPTH    = 2,
  parameter int STARVE_MAX   = 4,
  parameter int PASS_THROUGH = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_dat,
  output logic        o_alu_stall,
  input  logic        i_lsu_valid,
  output logic        o_lsu_ready,
  input  logic [4:0]  i_lsu_rd,
  input  logic [31:0] i_lsu_dat,
  input  logic        i_issue_valid,
  input  logic [4:0]  i_issue_rd,
  input  logic [4:0]  i_chk_rs1,
  input  logic [4:0]  i_chk_rs2,
  input  logic [4:0]  i_chk_rd,
  output logic        o_hazard,
  output logic [31:0] o_pending,
  output logic        o_we,
  output logic [4:0]  o_addr_wr,
  output logic [31:0] o_dat_wr
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] pend_q, pend_d, set_mask, clr_mask;
  logic we_q, we_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d, head_rd, sel_rd;
  logic [XLEN-1:0] dat_q, dat_d, head_dat, sel_dat;
  logic fifo_full, fifo_empty, push, pop, fwd_haz;
  wb_src_e src;

  regs_writer_fifo #(.WIDTH(REG_ADDR_W + XLEN), .DEPTH(LSU_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_dat   ({i_lsu_rd, i_lsu_dat}),
    .o_dat   ({head_rd, head_dat}),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  function automatic logic busy(input logic [XLEN-1:0] p, input logic [REG_ADDR_W-1:0] r);
    return (r != X0) && p[r];
  endfunction

  assign o_alu_stall = cnt_q >= CW'(STARVE_MAX);
  assign o_lsu_ready = !fifo_full;
  assign push = i_lsu_valid && o_lsu_ready;
  assign pop = src == SRC_LSU;
  assign o_we = we_q;
  assign o_addr_wr = addr_q;
  assign o_dat_wr = dat_q;
  assign o_pending = pend_q;

  // arbitration: ALU wins unless starved-out, otherwise drain the FIFO head
  always_comb begin
    src = (!o_alu_stall && i_alu_valid) ? SRC_ALU : (!fifo_empty ? SRC_LSU : SRC_NONE);
    sel_rd = (src == SRC_ALU) ? i_alu_rd : head_rd;
    sel_dat = (src == SRC_ALU) ? i_alu_dat : head_dat;
    we_d = (src != SRC_NONE) && (sel_rd != X0);
    addr_d = we_d ? sel_rd : addr_q;
    dat_d = we_d ? sel_dat : dat_q;
    cnt_d = (fifo_empty || pop) ? '0 : cnt_q + CW'(1);
  end

  // scoreboard next state; an issue in the same cycle as the clearing pop keeps the bit
  always_comb begin
    set_mask = (i_issue_valid && i_issue_rd != X0) ? (XLEN'(1) << i_issue_rd) : '0;
    clr_mask = pop ? (XLEN'(1) << head_rd) : '0;
    pend_d = (pend_q & ~clr_mask) | set_mask;
  end

  // hazard against pending long-latency results, plus the in-flight write without forwarding
  always_comb begin
    fwd_haz = (PASS_THROUGH == 0) && we_q &&
              ((addr_q == i_chk_rs1 && i_chk_rs1 != X0) || (addr_q == i_chk_rs2 && i_chk_rs2 != X0));
    o_hazard = busy(pend_q, i_chk_rs1) || busy(pend_q, i_chk_rs2) || busy(pend_q, i_chk_rd) || fwd_haz;
  end

  // output write port, starvation counter and scoreboard state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q <= 1'b0;
      addr_q <= '0;
      dat_q <= '0;
      cnt_q <= '0;
      pend_q <= '0;
    end else begin
      we_q <= we_d;
      addr_q <= addr_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
    end
  end
endmodule

// File: tb/tb_regs_writer.sv
// tb_regs_writer: table-driven directed checks of the regfile write front end
module tb_regs_writer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0] alu_rd = '0, lsu_rd = '0, issue_rd = '0, rs1 = '0, rs2 = '0, crd = '0;
  logic [31:0] alu_dat = '0, lsu_dat = '0;
  logic alu_stall, lsu_ready, hazard, we;
  logic [31:0] pending, dat_wr;
  logic [4:0] addr_wr;
  int n_vec = 0, n_cmp = 0, n_err = 0;

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] adat;
    logic lv; logic [4:0] lrd; logic [31:0] ldat;
    logic iv; logic [4:0] ird;
    logic [4:0] rs1, rs2, crd;
    logic e_stall, e_rdy, e_haz, e_we;
    logic [4:0] e_addr; logic [31:0] e_dat; logic [31:0] e_pend;
  } vec_t;
  vec_t vq[$];

  regs_writer dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_dat(alu_dat), .o_alu_stall(alu_stall),
    .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready), .i_lsu_rd(lsu_rd), .i_lsu_dat(lsu_dat),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
    .i_chk_rs1(rs1), .i_chk_rs2(rs2), .i_chk_rd(crd),
    .o_hazard(hazard), .o_pending(pending),
    .o_we(we), .o_addr_wr(addr_wr), .o_dat_wr(dat_wr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int av, ard, adat, lv, lrd, ldat, iv, ird, r1, r2, rd,
                     input int es, er, eh, ew, ea, ed, ep);
    vec_t v;
    v.av = 1'(av); v.ard = 5'(ard); v.adat = 32'(adat);
    v.lv = 1'(lv); v.lrd = 5'(lrd); v.ldat = 32'(ldat);
    v.iv = 1'(iv); v.ird = 5'(ird);
    v.rs1 = 5'(r1); v.rs2 = 5'(r2); v.crd = 5'(rd);
    v.e_stall = 1'(es); v.e_rdy = 1'(er); v.e_haz = 1'(eh); v.e_we = 1'(ew);
    v.e_addr = 5'(ea); v.e_dat = 32'(ed); v.e_pend = 32'(ep);
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
    alu_rd = 0; lsu_rd = 0; issue_rd = 0; rs1 = 0; rs2 = 0; crd = 0;
    alu_dat = 0; lsu_dat = 0;
  endtask

  initial begin
    //  av ard adat          lv lrd ldat         iv ird rs1 rs2 crd  stl rdy haz we addr dat           pend
    add(0, 0, 0,             0, 0, 0,            0, 0,  0, 0, 0,    0,  1,  0,  0, 0,   0,            0);
    add(1, 5, 32'hDEADBEEF,  0, 0, 0,            0, 0,  0, 0, 0,    0,  1,  0,  1, 5,   32'hDEADBEEF, 0);
    add(0, 0, 0,             0, 0, 0,            0, 0,  0, 0, 0,    0,  1,  0,  0, 0,   0,            0);
    add(0, 0, 0,             0, 0, 0,            1, 7,  0, 0, 0,    0,  1,  0,  0, 0,   0,            32'h80);
    add(0, 0, 0,             0, 0, 0,            0, 0,  7, 0, 0,    0,  1,  1,  0, 0,   0,            32'h80);
    add(0, 0, 0,             1, 7, 32'h12345678, 0, 0,  7, 0, 0,    0,  1,  1,  0, 0,   0,            32'h80);
    add(0, 0, 0,             0, 0, 0,            0, 0,  7, 0, 0,    0,  1,  1,  1, 7,   32'h12345678, 0);
    add(0, 0, 0,             0, 0, 0,            0, 0,  7, 0, 0,    0,  1,  0,  0, 0,   0,            0);
    add(1, 1, 32'h11,        1, 2, 32'h22,       0, 0,  0, 0, 0,    0,  1,  0,  1, 1,   32'h11,       0);
    add(1, 1, 32'h12,        1, 3, 32'h33,       0, 0,  0, 0, 0,    0,  1,  0,  1, 1,   32'h12,       0);
    add(1, 1, 32'h13,        1, 4, 32'h44,       0, 0,  0, 0, 0,    0,  0,  0,  1, 1,   32'h13,       0);
    add(1, 1, 32'h14,        1, 4, 32'h44,       0, 0,  0, 0, 0,    0,  0,  0,  1, 1,   32'h14,       0);
    add(1, 1, 32'h15,        1, 4, 32'h44,       0, 0,  0, 0, 0,    0,  0,  0,  1, 1,   32'h15,       0);
    add(1, 1, 32'h16,        1, 4, 32'h44,       0, 0,  0, 0, 0,    1,  0,  0,  1, 2,   32'h22,       0);
    add(1, 1, 32'h16,        1, 4, 32'h44,       0, 0,  0, 0, 0,    0,  1,  0,  1, 1,   32'h16,       0);
    add(0, 0, 0,             0, 0, 0,            0, 0,  0, 0, 0,    0,  0,  0,  1, 3,   32'h33,       0);
    add(0, 0, 0,             0, 0, 0,            0, 0,  0, 0, 0,    0,  1,  0,  1, 4,   32'h44,       0);
    add(0, 0, 0,             0, 0, 0,            0, 0,  0, 0, 0,    0,  1,  0,  0, 0,   0,            0);
    add(0, 0, 0,             1, 0, 32'h99,       1, 0,  0, 0, 0,    0,  1,  0,  0, 0,   0,            0);
    add(0, 0, 0,             0, 0, 0,            0, 0,  0, 0, 0,    0,  1,  0,  0, 0,   0,            0);
    add(0, 0, 0,             0, 0, 0,            1, 9,  0, 0, 0,    0,  1,  0,  0, 0,   0,            32'h200);
    add(0, 0, 0,             1, 9, 32'hAA,       0, 0,  0, 0, 9,    0,  1,  1,  0, 0,   0,            32'h200);
    add(0, 0, 0,             0, 0, 0,            1, 9,  0, 0, 0,    0,  1,  0,  1, 9,   32'hAA,       32'h200);
    add(0, 0, 0,             1, 9, 32'hBB,       0, 0,  0, 0, 0,    0,  1,  0,  0, 0,   0,            32'h200);
    add(0, 0, 0,             0, 0, 0,            0, 0,  0, 9, 0,    0,  1,  1,  1, 9,   32'hBB,       0);
    add(0, 0, 0,             0, 0, 0,            0, 0,  0, 0, 9,    0,  1,  0,  0, 0,   0,            0);

    repeat (2) @(negedge clk);
    chk("reset_we", {31'b0, we}, 0);
    chk("reset_addr", {27'b0, addr_wr}, 0);
    chk("reset_dat", dat_wr, 0);
    chk("reset_pend", pending, 0);
    chk("reset_rdy", {31'b0, lsu_ready}, 1);
    chk("reset_stall", {31'b0, alu_stall}, 0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      alu_valid = vq[i].av; alu_rd = vq[i].ard; alu_dat = vq[i].adat;
      lsu_valid = vq[i].lv; lsu_rd = vq[i].lrd; lsu_dat = vq[i].ldat;
      issue_valid = vq[i].iv; issue_rd = vq[i].ird;
      rs1 = vq[i].rs1; rs2 = vq[i].rs2; crd = vq[i].crd;
      #1;
      n_vec++;
      chk($sformatf("v%0d_stall", i), {31'b0, alu_stall}, {31'b0, vq[i].e_stall});
      chk($sformatf("v%0d_rdy", i), {31'b0, lsu_ready}, {31'b0, vq[i].e_rdy});
      chk($sformatf("v%0d_haz", i), {31'b0, hazard}, {31'b0, vq[i].e_haz});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", i), {31'b0, we}, {31'b0, vq[i].e_we});
      if (vq[i].e_we) begin
        chk($sformatf("v%0d_addr", i), {27'b0, addr_wr}, {27'b0, vq[i].e_addr});
        chk($sformatf("v%0d_dat", i), dat_wr, vq[i].e_dat);
      end
      chk($sformatf("v%0d_pend", i), pending, vq[i].e_pend);
    end

    // async reset with two FIFO entries, a pending bit and a live write
    @(negedge clk);
    idle_inputs();
    alu_valid = 1; alu_rd = 1; alu_dat = 32'h51;
    lsu_valid = 1; lsu_rd = 2; lsu_dat = 32'h61;
    issue_valid = 1; issue_rd = 5;
    @(negedge clk);
    issue_valid = 0;
    alu_dat = 32'h52; lsu_rd = 3; lsu_dat = 32'h62;
    @(posedge clk);
    #2;
    n_vec++;
    chk("pre_rst_we", {31'b0, we}, 1);
    chk("pre_rst_pend", pending, 32'h20);
    chk("pre_rst_rdy", {31'b0, lsu_ready}, 0);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_we", {31'b0, we}, 0);
    chk("rst_pend", pending, 0);
    chk("rst_rdy", {31'b0, lsu_ready}, 1);
    chk("rst_addr", {27'b0, addr_wr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      n_vec++;
      chk($sformatf("post_rst%0d_we", c), {31'b0, we}, 0);
      chk($sformatf("post_rst%0d_rdy", c), {31'b0, lsu_ready}, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
